// File: rtl/icache_param.sv
// icache_param: parametrised set-associative, read-only instruction cache
// sitting between CPU fetch and a memory burst-read port.
// Optional build macro ICACHE_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
module icache_param #(
  parameter int SET_NUM    = 8,
  parameter int WAY_NUM    = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        from_cpu_inst_req_valid,
  input  logic [31:0] from_cpu_inst_req_addr,
  output logic        to_cpu_inst_req_ready,
  output logic        to_cpu_cache_rsp_valid,
  output logic [31:0] to_cpu_cache_rsp_data,
  input  logic        from_cpu_cache_rsp_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int IDX_W = $clog2(SET_NUM);
  localparam int WAY_W = $clog2(WAY_NUM);
  localparam int WRD_W = $clog2(LINE_WORDS);
  localparam int OFF_W = WRD_W + 2;
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  typedef enum logic [7:0] {
    S_WAIT     = 8'b0000_0001,
    S_TAG_RD   = 8'b0000_0010,
    S_CACHE_RD = 8'b0000_0100,
    S_RESP     = 8'b0000_1000,
    S_EVICT    = 8'b0001_0000,
    S_MEM_RD   = 8'b0010_0000,
    S_RECV     = 8'b0100_0000,
    S_REFILL   = 8'b1000_0000
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      req_addr_q;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WRD_W-1:0] req_word;

  logic [SET_NUM-1:0] valid_q    [WAY_NUM];
  logic [TAG_W-1:0]   tag_q      [WAY_NUM][SET_NUM];
  logic [31:0]        data_q     [WAY_NUM][SET_NUM][LINE_WORDS];
  logic [WAY_W-1:0]   rr_ptr_q   [SET_NUM];
  logic [31:0]        line_buf_q [LINE_WORDS];
  logic [WRD_W-1:0]   beat_cnt_q;
  logic [WAY_W-1:0]   victim_q;
  logic [31:0]        rsp_data_q;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] evict_way;

  // Byte-offset bits of the latched address never select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_q[1:0];

  assign req_tag  = req_addr_q[31:32-TAG_W];
  assign req_idx  = req_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign req_word = req_addr_q[OFF_W-1:2];

  // Tag lookup across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim selection: lowest invalid way first, round-robin pointer otherwise.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    evict_way = inv_found ? inv_way : rr_ptr_q[req_idx];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  // FSM next state and state-decoded handshake outputs.
  always_comb begin
    state_d                = S_WAIT;
    to_cpu_inst_req_ready  = 1'b0;
    to_cpu_cache_rsp_valid = 1'b0;
    to_mem_rd_req_valid    = 1'b0;
    to_mem_rd_rsp_ready    = 1'b0;
    case (state_q)
      S_WAIT: begin
        to_cpu_inst_req_ready = 1'b1;
        state_d = from_cpu_inst_req_valid ? S_TAG_RD : S_WAIT;
      end
      S_TAG_RD:   state_d = hit ? S_CACHE_RD : S_EVICT;
      S_CACHE_RD: state_d = S_RESP;
      S_RESP: begin
        to_cpu_cache_rsp_valid = 1'b1;
        state_d = from_cpu_cache_rsp_ready ? S_WAIT : S_RESP;
      end
      S_EVICT:    state_d = S_MEM_RD;
      S_MEM_RD: begin
        to_mem_rd_req_valid = 1'b1;
        state_d = from_mem_rd_req_ready ? S_RECV : S_MEM_RD;
      end
      S_RECV: begin
        to_mem_rd_rsp_ready = 1'b1;
        state_d = (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) ? S_REFILL : S_RECV;
      end
      S_REFILL:   state_d = S_RESP;
      default:    state_d = S_WAIT;
    endcase
  end

  assign to_cpu_cache_rsp_data = rsp_data_q;
  assign to_mem_rd_req_addr    = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};

  // Control state: line valid bits, replacement pointers, beat counter, response word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAY_NUM; w++) valid_q[w] <= '0;
      for (int s = 0; s < SET_NUM; s++) rr_ptr_q[s] <= '0;
      beat_cnt_q <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        S_CACHE_RD: rsp_data_q <= data_q[hit_way][req_idx][req_word];
        S_EVICT: begin
          valid_q[evict_way][req_idx] <= 1'b0;
          if (!inv_found) rr_ptr_q[req_idx] <= rr_ptr_q[req_idx] + WAY_W'(1);
        end
        S_MEM_RD: if (from_mem_rd_req_ready) beat_cnt_q <= '0;
        S_RECV:   if (from_mem_rd_rsp_valid) beat_cnt_q <= beat_cnt_q + WRD_W'(1);
        S_REFILL: begin
          valid_q[victim_q][req_idx] <= 1'b1;
          rsp_data_q                 <= line_buf_q[req_word];
        end
        default: ;
      endcase
    end
  end

  // Datapath storage: request address, victim way, line buffer, tag and data arrays.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT && from_cpu_inst_req_valid) req_addr_q <= from_cpu_inst_req_addr;
    if (state_q == S_EVICT) victim_q <= evict_way;
    if (state_q == S_RECV && from_mem_rd_rsp_valid) line_buf_q[beat_cnt_q] <= from_mem_rd_rsp_data;
    if (state_q == S_REFILL) begin
      tag_q[victim_q][req_idx] <= req_tag;
      for (int i = 0; i < LINE_WORDS; i++) data_q[victim_q][req_idx][i] <= line_buf_q[i];
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Hit/miss event counters, sampled at the tag-compare cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == S_TAG_RD) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_param.sv
// Testbench for icache_param: default geometry instance plus a 4-set/2-way/16-word instance.
module tb_icache_param;
  localparam int SETS   = 8;
  localparam int WAYS   = 4;
  localparam int LW     = 8;
  localparam int LINE_B = LW * 4;
  localparam int B_LW   = 16;
  localparam int B_LINE = B_LW * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        from_cpu_inst_req_valid = 1'b0;
  logic [31:0] from_cpu_inst_req_addr = '0;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready = 1'b0;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready = 1'b0;
  logic        from_mem_rd_rsp_valid = 1'b0;
  logic [31:0] from_mem_rd_rsp_data = '0;
  logic        from_mem_rd_rsp_last = 1'b0;
  logic        to_mem_rd_rsp_ready;

  logic        b_req_valid = 1'b0;
  logic [31:0] b_req_addr = '0;
  logic        b_req_ready;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        b_rsp_ready = 1'b0;
  logic        b_mem_req_valid;
  logic [31:0] b_mem_req_addr;
  logic        b_mem_req_ready = 1'b0;
  logic        b_mem_rsp_valid = 1'b0;
  logic [31:0] b_mem_rsp_data = '0;
  logic        b_mem_rsp_last = 1'b0;
  logic        b_mem_rsp_ready;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, b_hit_cnt, b_miss_cnt;
`endif

  icache_param #(.SET_NUM(SETS), .WAY_NUM(WAYS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .from_cpu_inst_req_valid(from_cpu_inst_req_valid),
    .from_cpu_inst_req_addr(from_cpu_inst_req_addr),
    .to_cpu_inst_req_ready(to_cpu_inst_req_ready),
    .to_cpu_cache_rsp_valid(to_cpu_cache_rsp_valid),
    .to_cpu_cache_rsp_data(to_cpu_cache_rsp_data),
    .from_cpu_cache_rsp_ready(from_cpu_cache_rsp_ready),
    .to_mem_rd_req_valid(to_mem_rd_req_valid),
    .to_mem_rd_req_addr(to_mem_rd_req_addr),
    .from_mem_rd_req_ready(from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid(from_mem_rd_rsp_valid),
    .from_mem_rd_rsp_data(from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last(from_mem_rd_rsp_last),
    .to_mem_rd_rsp_ready(to_mem_rd_rsp_ready)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  icache_param #(.SET_NUM(4), .WAY_NUM(2), .LINE_WORDS(B_LW)) dut_b (
    .clk(clk), .rst(rst),
    .from_cpu_inst_req_valid(b_req_valid),
    .from_cpu_inst_req_addr(b_req_addr),
    .to_cpu_inst_req_ready(b_req_ready),
    .to_cpu_cache_rsp_valid(b_rsp_valid),
    .to_cpu_cache_rsp_data(b_rsp_data),
    .from_cpu_cache_rsp_ready(b_rsp_ready),
    .to_mem_rd_req_valid(b_mem_req_valid),
    .to_mem_rd_req_addr(b_mem_req_addr),
    .from_mem_rd_req_ready(b_mem_req_ready),
    .from_mem_rd_rsp_valid(b_mem_rsp_valid),
    .from_mem_rd_rsp_data(b_mem_rsp_data),
    .from_mem_rd_rsp_last(b_mem_rsp_last),
    .to_mem_rd_rsp_ready(b_mem_rsp_ready)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per set, which memory line number each way holds.
  bit          m_valid [WAYS][SETS];
  int unsigned m_line  [WAYS][SETS];
  int          m_rr    [SETS];
  int          exp_hits;
  int          exp_misses;

  // Backing memory contents: line 0x100 holds 0xA0..0xA7, elsewhere an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ((a >> 5) == 32'h8) return 32'hA0 + {29'd0, a[4:2]};
    return {a[15:0], 16'h0} ^ {8'h5c, a[31:8]} ^ 32'h0000_3c00 ^ (a >> 2);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[w][s] = 1'b0;
        m_line[w][s]  = 0;
      end
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic model_access(input logic [31:0] a, output bit hit);
    int unsigned ln;
    int s;
    int v;
    ln  = a / LINE_B;
    s   = int'(ln % SETS);
    v   = -1;
    hit = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][s] && m_line[w][s] == ln) hit = 1'b1;
    if (hit) begin
      exp_hits++;
      return;
    end
    exp_misses++;
    for (int w = 0; w < WAYS; w++)
      if (!m_valid[w][s] && v < 0) v = w;
    if (v < 0) begin
      v       = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[v][s] = 1'b1;
    m_line[v][s]  = ln;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    from_cpu_inst_req_valid = 1'b0; from_cpu_cache_rsp_ready = 1'b0;
    from_mem_rd_req_ready = 1'b0; from_mem_rd_rsp_valid = 1'b0; from_mem_rd_rsp_last = 1'b0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b0; b_mem_req_ready = 1'b0;
    b_mem_rsp_valid = 1'b0; b_mem_rsp_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Deliver one full line on the default instance's memory port, with random idle gaps.
  task automatic send_line(input logic [31:0] base);
    for (int b = 0; b < LW; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        from_mem_rd_rsp_valid = 1'b0;
        @(negedge clk);
      end
      n_cmp++;
      if (to_mem_rd_rsp_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mem_rsp_ready beat %0d: got %b want 1", b, to_mem_rd_rsp_ready);
      end
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = mem_word(base + 32'(b * 4));
      from_mem_rd_rsp_last  = (b == LW - 1);
      @(negedge clk);
    end
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_last  = 1'b0;
  endtask

  // One complete fetch on the default instance, checked against the model.
  task automatic fetch(input logic [31:0] a, input int rsp_stall, input int mem_stall, input bit chk_lat);
    bit          exp_hit;
    bit          saw_mem;
    int          cyc;
    logic [31:0] got;
    logic [31:0] exp_d;
    logic [31:0] exp_maddr;
    model_access(a, exp_hit);
    exp_d     = mem_word(a);
    exp_maddr = a & ~32'(LINE_B - 1);
    @(negedge clk);
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = a;
    n_cmp++;
    if (to_cpu_inst_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready idle @%h: got %b want 1", a, to_cpu_inst_req_ready);
    end
    @(negedge clk);
    from_cpu_inst_req_valid = 1'b0;
    from_cpu_inst_req_addr  = $urandom & 32'hFFFF_FFFC;
    cyc     = 1;
    saw_mem = 1'b0;
    while (!to_cpu_cache_rsp_valid && !to_mem_rd_req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (to_mem_rd_req_valid === 1'b1) begin
      saw_mem = 1'b1;
      n_cmp++;
      if (to_mem_rd_req_addr !== exp_maddr) begin
        n_fail++;
        $display("FAIL mem_req_addr @%h: got %h want %h", a, to_mem_rd_req_addr, exp_maddr);
      end
      for (int i = 0; i < mem_stall; i++) begin
        @(negedge clk);
        n_cmp++;
        if (to_mem_rd_req_valid !== 1'b1 || to_mem_rd_req_addr !== exp_maddr || to_cpu_cache_rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL mem_req_hold cyc %0d: got v=%b a=%h want v=1 a=%h", i, to_mem_rd_req_valid, to_mem_rd_req_addr, exp_maddr);
        end
      end
      from_mem_rd_req_ready = 1'b1;
      @(negedge clk);
      from_mem_rd_req_ready = 1'b0;
      send_line(exp_maddr);
      cyc = 0;
      while (!to_cpu_cache_rsp_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (saw_mem !== !exp_hit) begin
      n_fail++;
      $display("FAIL miss_detect @%h: got miss=%b want miss=%b", a, saw_mem, !exp_hit);
    end
    n_cmp++;
    if (to_cpu_cache_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_timeout @%h: got rsp_valid=%b want 1", a, to_cpu_cache_rsp_valid);
      return;
    end
    if (chk_lat && exp_hit) begin
      // Handshake cycle plus TAG_RD and CACHE_RD: rsp_valid seen on the third cycle after.
      n_cmp++;
      if (cyc !== 3) begin
        n_fail++;
        $display("FAIL hit_latency @%h: got %0d want 3", a, cyc);
      end
    end
    got = to_cpu_cache_rsp_data;
    n_cmp++;
    if (got !== exp_d) begin
      n_fail++;
      $display("FAIL rsp_data @%h: got %h want %h", a, got, exp_d);
    end
    for (int i = 0; i < rsp_stall; i++) begin
      @(negedge clk);
      n_cmp++;
      if (to_cpu_cache_rsp_valid !== 1'b1 || to_cpu_cache_rsp_data !== exp_d || to_cpu_inst_req_ready !== 1'b0
          || to_mem_rd_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_hold cyc %0d: got v=%b d=%h want v=1 d=%h", i, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data, exp_d);
      end
    end
    from_cpu_cache_rsp_ready = 1'b1;
    @(negedge clk);
    from_cpu_cache_rsp_ready = 1'b0;
    n_cmp++;
    if (to_cpu_cache_rsp_valid !== 1'b0 || to_cpu_inst_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_wait @%h: got v=%b rdy=%b want v=0 rdy=1", a, to_cpu_cache_rsp_valid, to_cpu_inst_req_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 1000",
               {to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready});
    end
    n_cmp++;
    if (to_cpu_cache_rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rsp_data: got %h want 00000000", to_cpu_cache_rsp_data);
    end
    n_cmp++;
    if ({b_req_ready, b_rsp_valid, b_mem_req_valid, b_mem_rsp_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %b want 1000", {b_req_ready, b_rsp_valid, b_mem_req_valid, b_mem_rsp_ready});
    end
`ifdef ICACHE_PERF_CNT_EN
    n_cmp++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0104, 0, 0, 1'b0);
  endtask

  task automatic test_hit();
    fetch(32'h0000_0104, 0, 0, 1'b1);
`ifdef ICACHE_PERF_CNT_EN
    n_cmp++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_after_hit: got %0d/%0d want 1/1", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_eviction();
    do_reset();
    for (int i = 0; i < 5; i++) fetch(32'(i) << 8, 0, 0, 1'b0);
    fetch(32'h0000_0100, 0, 0, 1'b1);
    fetch(32'h0000_0000, 0, 0, 1'b0);
    fetch(32'h0000_0408, 0, 0, 1'b1);
  endtask

  task automatic test_stalls();
    fetch(32'h0000_2A6C, 10, 5, 1'b0);
    fetch(32'h0000_2A60, 10, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 7)) << 5) | (32'($urandom_range(0, 7)) << 2);
      fetch(a, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    end
`ifdef ICACHE_PERF_CNT_EN
    n_cmp++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      n_fail++;
      $display("FAIL perf_random: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_reset_recv();
    int cyc;
    @(negedge clk);
    from_cpu_inst_req_valid = 1'b1;
    from_cpu_inst_req_addr  = 32'h0000_7E04;
    @(negedge clk);
    from_cpu_inst_req_valid = 1'b0;
    cyc = 0;
    while (!to_mem_rd_req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (to_mem_rd_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_mem_req: got %b want 1", to_mem_rd_req_valid);
    end
    from_mem_rd_req_ready = 1'b1;
    @(negedge clk);
    from_mem_rd_req_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = 32'hDEAD_0000 + 32'(b);
      @(negedge clk);
    end
    from_mem_rd_rsp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_in_recv: got %b want 1000",
               {to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready});
    end
    rst = 1'b0;
    model_reset();
    fetch(32'h0000_7E04, 0, 0, 1'b0);
    fetch(32'h0000_0104, 0, 0, 1'b0);
  endtask

  // Alternate geometry: 4 sets, 2 ways, 16-word lines.
  task automatic b_fetch(input logic [31:0] a, input bit exp_miss);
    int          cyc;
    bit          saw_mem;
    logic [31:0] exp_maddr;
    exp_maddr = a & ~32'(B_LINE - 1);
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_addr  = a;
    @(negedge clk);
    b_req_valid = 1'b0;
    cyc = 0;
    saw_mem = 1'b0;
    while (!b_rsp_valid && !b_mem_req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (b_mem_req_valid === 1'b1) begin
      saw_mem = 1'b1;
      n_cmp++;
      if (b_mem_req_addr !== exp_maddr) begin
        n_fail++;
        $display("FAIL b_mem_req_addr @%h: got %h want %h", a, b_mem_req_addr, exp_maddr);
      end
      b_mem_req_ready = 1'b1;
      @(negedge clk);
      b_mem_req_ready = 1'b0;
      for (int b = 0; b < B_LW; b++) begin
        b_mem_rsp_valid = 1'b1;
        b_mem_rsp_data  = mem_word(exp_maddr + 32'(b * 4));
        b_mem_rsp_last  = (b == B_LW - 1);
        @(negedge clk);
      end
      b_mem_rsp_valid = 1'b0;
      b_mem_rsp_last  = 1'b0;
      cyc = 0;
      while (!b_rsp_valid && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (saw_mem !== exp_miss) begin
      n_fail++;
      $display("FAIL b_miss_detect @%h: got %b want %b", a, saw_mem, exp_miss);
    end
    n_cmp++;
    if (b_rsp_valid !== 1'b1 || b_rsp_data !== mem_word(a)) begin
      n_fail++;
      $display("FAIL b_rsp @%h: got v=%b d=%h want v=1 d=%h", a, b_rsp_valid, b_rsp_data, mem_word(a));
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_alt_config();
    do_reset();
    b_fetch(32'h0000_1274, 1'b1);
    b_fetch(32'h0000_1274, 1'b0);
    b_fetch(32'h0000_127C, 1'b0);
    b_fetch(32'h0000_1240, 1'b0);
    b_fetch(32'h0000_5A3C, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_cold_miss();
    test_hit();
    test_eviction();
    test_stalls();
    test_random();
    test_reset_recv();
    test_alt_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
